// File: rtl/renkon_ctrl_core_gen_if.sv
// Bus bundle between the renkon layer sequencer and its environment (host, image/net
// memories, line buffer, weight/bias registers, pipeline and output serializer).
//   slave  : the sequencer side (takes host request/fields, drives memory and pipeline controls)
//   master : the environment side (host, memories and serializer)
// Host request : req, total_out, total_in, img_size, fil_size, stride, input_addr, output_addr
// Host writes  : img_we, host_img_addr, write_img, net_we, net_sel, net_addr
// Serializer   : write_result (in), serial_we, serial_re, serial_addr (out)
// Status       : ack, core_state
// Memories     : mem_img_we/mem_img_addr/write_mem_img, mem_net_we/mem_net_addr
// Datapath     : buf_pix_en, wreg_we, breg_we, first_input, last_input,
//                out_start, out_valid, out_stop
interface renkon_ctrl_core_gen_if #(
    parameter int unsigned DWIDTH  = 16,
    parameter int unsigned LWIDTH  = 10,
    parameter int unsigned IMGSIZE = 12,
    parameter int unsigned NETSIZE = 11,
    parameter int unsigned OUTSIZE = 10,
    parameter int unsigned CORE    = 8
);
    localparam int unsigned CORELOG = $clog2(CORE);

    logic                 req;
    logic [LWIDTH-1:0]    total_out;
    logic [LWIDTH-1:0]    total_in;
    logic [LWIDTH-1:0]    img_size;
    logic [LWIDTH-1:0]    fil_size;
    logic                 stride;
    logic [IMGSIZE-1:0]   input_addr;
    logic [IMGSIZE-1:0]   output_addr;
    logic                 img_we;
    logic                 net_we;
    logic [IMGSIZE-1:0]   host_img_addr;
    logic [DWIDTH-1:0]    write_img;
    logic [CORELOG-1:0]   net_sel;
    logic [NETSIZE-1:0]   net_addr;
    logic [DWIDTH-1:0]    write_result;

    logic                 ack;
    logic [1:0]           core_state;
    logic                 mem_img_we;
    logic [IMGSIZE-1:0]   mem_img_addr;
    logic [DWIDTH-1:0]    write_mem_img;
    logic [CORE-1:0]      mem_net_we;
    logic [NETSIZE-1:0]   mem_net_addr;
    logic                 buf_pix_en;
    logic                 wreg_we;
    logic                 breg_we;
    logic                 first_input;
    logic                 last_input;
    logic                 out_start;
    logic                 out_valid;
    logic                 out_stop;
    logic                 serial_we;
    logic [CORELOG:0]     serial_re;
    logic [OUTSIZE-1:0]   serial_addr;

    modport slave (
        input  req, total_out, total_in, img_size, fil_size, stride, input_addr, output_addr,
        input  img_we, net_we, host_img_addr, write_img, net_sel, net_addr, write_result,
        output ack, core_state, mem_img_we, mem_img_addr, write_mem_img, mem_net_we,
        output mem_net_addr, buf_pix_en, wreg_we, breg_we, first_input, last_input,
        output out_start, out_valid, out_stop, serial_we, serial_re, serial_addr
    );

    modport master (
        output req, total_out, total_in, img_size, fil_size, stride, input_addr, output_addr,
        output img_we, net_we, host_img_addr, write_img, net_sel, net_addr, write_result,
        input  ack, core_state, mem_img_we, mem_img_addr, write_mem_img, mem_net_we,
        input  mem_net_addr, buf_pix_en, wreg_we, breg_we, first_input, last_input,
        input  out_start, out_valid, out_stop, serial_we, serial_re, serial_addr
    );
endinterface

// File: rtl/renkon_ctrl_core_gen.sv
// Layer sequencer for the renkon conv engine with CORE parallel output channels.
// For every output group g it walks all input channels (weight load, then an n*n raster
// of the input image), then drains the active cores of the serializer back into image
// memory. Host writes pass straight through to the memories while idle.
// Ports:
//   clk  : clock, all state on posedge
//   rst  : synchronous active-high reset
//   bus  : slave side of renkon_ctrl_core_gen_if (host request, memories, pipeline, serializer)
module renkon_ctrl_core_gen #(
    parameter int unsigned DWIDTH  = 16,
    parameter int unsigned LWIDTH  = 10,
    parameter int unsigned IMGSIZE = 12,
    parameter int unsigned NETSIZE = 11,
    parameter int unsigned OUTSIZE = 10,
    parameter int unsigned CORE    = 8
) (
    input logic                    clk,
    input logic                    rst,
    renkon_ctrl_core_gen_if.slave  bus
);
    localparam int unsigned CORELOG = $clog2(CORE);
    localparam int unsigned GW      = LWIDTH + 1;   // group count / channel remainder
    localparam int unsigned PW      = 2 * LWIDTH;   // f*f and o*o products

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWgt  = 2'd1,
        StAcc  = 2'd2,
        StOut  = 2'd3
    } state_e;

    state_e               state_q;
    logic                 ack_q;

    // Layer fields latched on req
    logic [LWIDTH-1:0]    tout_q, tin_q, n_q, f_q;
    logic                 stride_q;
    logic [IMGSIZE-1:0]   in_base_q, out_base_q;

    // Loop counters
    logic [GW-1:0]        g_q;
    logic [LWIDTH-1:0]    i_q;
    logic [PW-1:0]        k_q;        // weight step; k == f*f is the bias cycle
    logic [LWIDTH-1:0]    y_q, x_q;
    logic [CORELOG:0]     r_q;
    logic [PW-1:0]        p_q;

    // Running address offsets; each sequence is contiguous so no multipliers are needed
    logic [NETSIZE-1:0]   net_off_q;  // (g*total_in+i)*f*f+k across the whole layer
    logic [IMGSIZE-1:0]   img_off_q;  // i*n*n+y*n+x, restarted per group
    logic [IMGSIZE-1:0]   out_off_q;  // (g*CORE+r)*o*o+k, continuous across full groups
    logic [OUTSIZE-1:0]   sidx_q;     // output pixel index during ACC

    // Derived layer geometry
    logic [PW-1:0]        ff, oo;
    logic [LWIDTH-1:0]    o_edge, fm1, last_pos;
    logic [GW-1:0]        groups, rem, active;
    logic [NETSIZE-1:0]   bias_addr;

    // Step decode
    logic                 first_in, last_in, wgt_bias, wgt_last;
    logic                 pix_valid, pix_start, pix_stop, row_end, chan_end;
    logic                 core_end, pix_end, last_group, degenerate;

    always_comb begin
        ff         = PW'(f_q) * PW'(f_q);
        o_edge     = LWIDTH'((n_q - f_q) >> stride_q) + LWIDTH'(1);
        oo         = PW'(o_edge) * PW'(o_edge);
        fm1        = f_q - LWIDTH'(1);
        last_pos   = fm1 + LWIDTH'((o_edge - LWIDTH'(1)) << stride_q);
        groups     = GW'(({1'b0, tout_q} + GW'(CORE - 1)) >> CORELOG);
        rem        = {1'b0, tout_q} - (g_q << CORELOG);
        active     = (rem > GW'(CORE)) ? GW'(CORE) : rem;
        // Biases sit after every weight of the layer; modular product is enough
        bias_addr  = NETSIZE'(groups) * NETSIZE'(tin_q) * NETSIZE'(ff) + NETSIZE'(g_q);

        first_in   = (i_q == '0);
        last_in    = (i_q == tin_q - LWIDTH'(1));
        wgt_bias   = first_in && (k_q == ff);
        wgt_last   = first_in ? (k_q == ff) : (k_q == ff - PW'(1));

        // For stride 2 the offset from f-1 must be even; LSB of a difference is an xor
        pix_valid  = (y_q >= fm1) && (x_q >= fm1) &&
                     (!stride_q || (!(y_q[0] ^ fm1[0]) && !(x_q[0] ^ fm1[0])));
        pix_start  = pix_valid && (y_q == fm1) && (x_q == fm1);
        pix_stop   = pix_valid && (y_q == last_pos) && (x_q == last_pos);
        row_end    = (x_q == n_q - LWIDTH'(1));
        chan_end   = row_end && (y_q == n_q - LWIDTH'(1));

        pix_end    = (p_q == oo - PW'(1));
        core_end   = (GW'(r_q) == active - GW'(1));
        last_group = (g_q == groups - GW'(1));

        degenerate = (bus.total_in == '0) || (bus.total_out == '0) ||
                     (bus.fil_size == '0) || (bus.fil_size > bus.img_size);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            ack_q      <= 1'b0;
            tout_q     <= '0;
            tin_q      <= '0;
            n_q        <= '0;
            f_q        <= '0;
            stride_q   <= 1'b0;
            in_base_q  <= '0;
            out_base_q <= '0;
            g_q        <= '0;
            i_q        <= '0;
            k_q        <= '0;
            y_q        <= '0;
            x_q        <= '0;
            r_q        <= '0;
            p_q        <= '0;
            net_off_q  <= '0;
            img_off_q  <= '0;
            out_off_q  <= '0;
            sidx_q     <= '0;
        end else begin
            ack_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.req) begin
                        tout_q     <= bus.total_out;
                        tin_q      <= bus.total_in;
                        n_q        <= bus.img_size;
                        f_q        <= bus.fil_size;
                        stride_q   <= bus.stride;
                        in_base_q  <= bus.input_addr;
                        out_base_q <= bus.output_addr;
                        g_q        <= '0;
                        i_q        <= '0;
                        k_q        <= '0;
                        net_off_q  <= '0;
                        img_off_q  <= '0;
                        out_off_q  <= '0;
                        if (degenerate) begin
                            ack_q <= 1'b1;
                        end else begin
                            state_q <= StWgt;
                        end
                    end
                end
                StWgt: begin
                    if (!wgt_bias) begin
                        net_off_q <= net_off_q + NETSIZE'(1);
                    end
                    if (wgt_last) begin
                        state_q <= StAcc;
                        k_q     <= '0;
                        y_q     <= '0;
                        x_q     <= '0;
                        sidx_q  <= '0;
                    end else begin
                        k_q <= k_q + PW'(1);
                    end
                end
                StAcc: begin
                    img_off_q <= img_off_q + IMGSIZE'(1);
                    if (pix_valid) begin
                        sidx_q <= sidx_q + OUTSIZE'(1);
                    end
                    if (row_end) begin
                        x_q <= '0;
                        y_q <= y_q + LWIDTH'(1);
                    end else begin
                        x_q <= x_q + LWIDTH'(1);
                    end
                    if (chan_end) begin
                        if (last_in) begin
                            state_q <= StOut;
                            r_q     <= '0;
                            p_q     <= '0;
                        end else begin
                            state_q <= StWgt;
                            i_q     <= i_q + LWIDTH'(1);
                            k_q     <= '0;
                        end
                    end
                end
                StOut: begin
                    out_off_q <= out_off_q + IMGSIZE'(1);
                    if (pix_end) begin
                        p_q <= '0;
                        if (core_end) begin
                            if (last_group) begin
                                state_q <= StIdle;
                                ack_q   <= 1'b1;
                            end else begin
                                state_q   <= StWgt;
                                g_q       <= g_q + GW'(1);
                                i_q       <= '0;
                                k_q       <= '0;
                                img_off_q <= '0;
                            end
                        end else begin
                            r_q <= r_q + (CORELOG+1)'(1);
                        end
                    end else begin
                        p_q <= p_q + PW'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Outputs decode the registered sequencer state; in IDLE the host strobes pass through.
    always_comb begin
        bus.ack           = ack_q;
        bus.core_state    = state_q;
        bus.mem_img_we    = 1'b0;
        bus.mem_img_addr  = '0;
        bus.write_mem_img = {DWIDTH{1'b0}};
        bus.mem_net_we    = '0;
        bus.mem_net_addr  = '0;
        bus.buf_pix_en    = 1'b0;
        bus.wreg_we       = 1'b0;
        bus.breg_we       = 1'b0;
        bus.first_input   = 1'b0;
        bus.last_input    = 1'b0;
        bus.out_start     = 1'b0;
        bus.out_valid     = 1'b0;
        bus.out_stop      = 1'b0;
        bus.serial_we     = 1'b0;
        bus.serial_re     = '0;
        bus.serial_addr   = '0;
        unique case (state_q)
            StIdle: begin
                bus.mem_img_we    = bus.img_we;
                bus.mem_img_addr  = bus.host_img_addr;
                bus.write_mem_img = bus.write_img;
                bus.mem_net_we    = bus.net_we ? (CORE'(1) << bus.net_sel) : '0;
                bus.mem_net_addr  = bus.net_addr;
            end
            StWgt: begin
                bus.wreg_we      = !wgt_bias;
                bus.breg_we      = wgt_bias;
                bus.mem_net_addr = wgt_bias ? bias_addr : net_off_q;
                bus.first_input  = first_in;
                bus.last_input   = last_in;
            end
            StAcc: begin
                bus.buf_pix_en   = 1'b1;
                bus.mem_img_addr = in_base_q + img_off_q;
                bus.first_input  = first_in;
                bus.last_input   = last_in;
                bus.out_valid    = pix_valid;
                bus.out_start    = pix_start;
                bus.out_stop     = pix_stop;
                bus.serial_we    = pix_valid && last_in;
                bus.serial_addr  = sidx_q;
            end
            StOut: begin
                bus.mem_img_we    = 1'b1;
                bus.mem_img_addr  = out_base_q + out_off_q;
                bus.write_mem_img = bus.write_result;
                bus.serial_re     = r_q + (CORELOG+1)'(1);
                bus.serial_addr   = OUTSIZE'(p_q);
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_renkon_ctrl_core_gen.sv
module tb_renkon_ctrl_core_gen;
    localparam int unsigned DWIDTH  = 16;
    localparam int unsigned LWIDTH  = 10;
    localparam int unsigned IMGSIZE = 12;
    localparam int unsigned NETSIZE = 11;
    localparam int unsigned OUTSIZE = 10;
    localparam int unsigned CORE    = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    renkon_ctrl_core_gen_if #(
        .DWIDTH(DWIDTH), .LWIDTH(LWIDTH), .IMGSIZE(IMGSIZE),
        .NETSIZE(NETSIZE), .OUTSIZE(OUTSIZE), .CORE(CORE)
    ) bus ();

    renkon_ctrl_core_gen #(
        .DWIDTH(DWIDTH), .LWIDTH(LWIDTH), .IMGSIZE(IMGSIZE),
        .NETSIZE(NETSIZE), .OUTSIZE(OUTSIZE), .CORE(CORE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Serializer model: data tagged with the selected core and pixel
    assign bus.write_result = {2'b00, bus.serial_re, bus.serial_addr} ^ 16'h5A00;

    typedef struct packed {
        logic [11:0] addr;
        logic [15:0] data;
        logic [3:0]  re;
        logic [9:0]  sa;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int failures = 0;
    int busy_cnt = 0, ack_cnt = 0, wreg_cnt = 0, breg_cnt = 0, valid_cnt = 0;
    int sw_cnt = 0, pix_cnt = 0, img_we_cnt = 0, busy_wr_cnt = 0;
    int acc_idx = 0, start_idx = -1, stop_idx = -1;
    logic [10:0] last_bias = '0;
    bit acc_chk = 1'b0;
    logic [11:0] acc_base = '0;

    task automatic check(input string tag, input logic [63:0] obsv, input logic [63:0] expv);
        checks++;
        assert (obsv === expv) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obsv, expv);
        end
    endtask

    // One clock: advance to the falling edge and observe the DUT there.
    task automatic tick();
        exp_t e;
        exp_t o;
        @(negedge clk);
        if (bus.core_state != 2'd0) busy_cnt++;
        if (bus.ack) ack_cnt++;
        if (bus.wreg_we) wreg_cnt++;
        if (bus.mem_img_we) img_we_cnt++;
        if (bus.breg_we) begin
            breg_cnt++;
            last_bias = bus.mem_net_addr;
        end
        if ((bus.core_state == 2'd1 || bus.core_state == 2'd2) &&
            (bus.mem_img_we || bus.mem_net_we != '0)) busy_wr_cnt++;
        if (bus.buf_pix_en) begin
            pix_cnt++;
            if (acc_chk) check("acc_addr", bus.mem_img_addr, acc_base + 12'(acc_idx));
            if (bus.out_valid) valid_cnt++;
            if (bus.serial_we) sw_cnt++;
            if (bus.out_start) start_idx = acc_idx;
            if (bus.out_stop) stop_idx = acc_idx;
            acc_idx++;
        end else begin
            acc_idx = 0;
        end
        if (bus.core_state == 2'd3 && bus.mem_img_we) begin
            o.addr = bus.mem_img_addr;
            o.data = bus.write_mem_img;
            o.re   = bus.serial_re;
            o.sa   = bus.serial_addr;
            if (sb.size() == 0) begin
                check("out_unexpected", o, '0);
            end else begin
                e = sb.pop_front();
                check("out_write", o, e);
            end
        end
    endtask

    task automatic push_out(input int n_out, input int oo, input logic [11:0] base);
        for (int ch = 0; ch < n_out; ch++) begin
            for (int k = 0; k < oo; k++) begin
                exp_t e;
                e.re   = 4'((ch % CORE) + 1);
                e.sa   = 10'(k);
                e.addr = base + 12'(ch * oo + k);
                e.data = {2'b00, e.re, e.sa} ^ 16'h5A00;
                sb.push_back(e);
            end
        end
    endtask

    task automatic start_layer(input int tout, input int tin, input int n, input int f,
                               input bit s, input logic [11:0] ib, input logic [11:0] ob);
        bus.total_out   = 10'(tout);
        bus.total_in    = 10'(tin);
        bus.img_size    = 10'(n);
        bus.fil_size    = 10'(f);
        bus.stride      = s;
        bus.input_addr  = ib;
        bus.output_addr = ob;
        bus.req         = 1'b1;
        tick();
        bus.req = 1'b0;
    endtask

    task automatic wait_state(input logic [1:0] st, input int budget);
        int c = 0;
        while (bus.core_state != st && c < budget) begin
            tick();
            c++;
        end
        check("reach_state", bus.core_state, st);
    endtask

    task automatic run_until_ack(input int budget);
        int c = 0;
        while (!bus.ack && c < budget) begin
            tick();
            c++;
        end
        check("ack_seen", bus.ack, 1'b1);
    endtask

    int b_busy, b_ack, b_wreg, b_breg, b_valid, b_sw, b_pix, b_img, b_bw;

    task automatic snap();
        b_busy = busy_cnt; b_ack = ack_cnt; b_wreg = wreg_cnt; b_breg = breg_cnt;
        b_valid = valid_cnt; b_sw = sw_cnt; b_pix = pix_cnt; b_img = img_we_cnt;
        b_bw = busy_wr_cnt;
    endtask

    initial begin
        rst = 1'b1;
        bus.req = 0; bus.total_out = '0; bus.total_in = '0; bus.img_size = '0;
        bus.fil_size = '0; bus.stride = 0; bus.input_addr = '0; bus.output_addr = '0;
        bus.img_we = 0; bus.net_we = 0; bus.host_img_addr = '0; bus.write_img = '0;
        bus.net_sel = '0; bus.net_addr = '0;
        tick();
        tick();
        check("rst_state", bus.core_state, 2'd0);
        check("rst_ack", bus.ack, 1'b0);
        check("rst_outs", {bus.mem_img_we, bus.mem_net_we, bus.buf_pix_en, bus.wreg_we,
                           bus.breg_we, bus.out_valid, bus.serial_we, bus.serial_re}, '0);
        rst = 1'b0;
        tick();

        // Host pass-through in IDLE
        bus.img_we = 1; bus.host_img_addr = 12'h5A5; bus.write_img = 16'hBEEF;
        bus.net_we = 1; bus.net_sel = 3'd3; bus.net_addr = 11'h2AB;
        #1;
        check("host_img_we", bus.mem_img_we, 1'b1);
        check("host_img_addr", bus.mem_img_addr, 12'h5A5);
        check("host_img_data", bus.write_mem_img, 16'hBEEF);
        check("host_net_we", bus.mem_net_we, 8'h08);
        check("host_net_addr", bus.mem_net_addr, 11'h2AB);
        tick();
        bus.img_we = 0; bus.host_img_addr = '0; bus.write_img = '0;
        bus.net_we = 0; bus.net_sel = '0; bus.net_addr = '0;
        tick();

        // Degenerate requests: f > n, then total_in == 0
        snap();
        start_layer(4, 2, 5, 7, 0, 12'd0, 12'd0);
        check("degen_ack", bus.ack, 1'b1);
        check("degen_state", bus.core_state, 2'd0);
        tick();
        tick();
        check("degen_ack_pulse", ack_cnt - b_ack, 1);
        check("degen_traffic", {wreg_cnt - b_wreg, pix_cnt - b_pix, img_we_cnt - b_img}, '0);
        start_layer(4, 0, 6, 3, 0, 12'd0, 12'd0);
        check("degen_tin0_ack", bus.ack, 1'b1);
        tick();

        // out=8 in=1 n=6 f=3 stride 1, results to 3000
        snap();
        acc_chk = 1'b1; acc_base = 12'd40;
        push_out(8, 16, 12'd3000);
        start_layer(8, 1, 6, 3, 0, 12'd40, 12'd3000);
        check("small_wgt_state", bus.core_state, 2'd1);
        check("small_wgt_first", {bus.wreg_we, bus.first_input, bus.last_input}, 3'b111);
        check("small_wgt_addr0", bus.mem_net_addr, 11'd0);
        run_until_ack(2000);
        check("small_sb_drain", sb.size(), 0);
        check("small_busy", busy_cnt - b_busy, 174);
        check("small_wreg", wreg_cnt - b_wreg, 9);
        check("small_breg", breg_cnt - b_breg, 1);
        check("small_bias_addr", last_bias, 11'd9);
        check("small_valid", valid_cnt - b_valid, 16);
        check("small_start", start_idx, 14);
        check("small_stop", stop_idx, 35);
        check("small_serial_we", sw_cnt - b_sw, 16);
        tick();
        check("small_ack_pulse", bus.ack, 1'b0);

        // n=12 f=4 stride 2
        snap();
        acc_base = 12'd200;
        push_out(1, 25, 12'd1000);
        start_layer(1, 1, 12, 4, 1, 12'd200, 12'd1000);
        run_until_ack(1000);
        check("s2_sb_drain", sb.size(), 0);
        check("s2_valid", valid_cnt - b_valid, 25);
        check("s2_start", start_idx, 39);
        check("s2_stop", stop_idx, 143);
        check("s2_serial_we", sw_cnt - b_sw, 25);
        check("s2_wreg", wreg_cnt - b_wreg, 16);
        check("s2_bias_addr", last_bias, 11'd16);
        check("s2_busy", busy_cnt - b_busy, 186);
        tick();

        // Full layer with partial last group; host strobes and req while busy are ignored
        snap();
        acc_chk = 1'b0;
        push_out(50, 64, 12'd100);
        start_layer(50, 20, 12, 5, 0, 12'd0, 12'd100);
        wait_state(2'd2, 100);
        bus.img_we = 1; bus.net_we = 1; bus.net_sel = 3'd1; bus.req = 1;
        bus.host_img_addr = 12'h123; bus.net_addr = 11'h055;
        #1;
        check("busy_img_we", bus.mem_img_we, 1'b0);
        check("busy_net_we", bus.mem_net_we, 8'h00);
        tick();
        bus.img_we = 0; bus.net_we = 0; bus.net_sel = '0; bus.req = 0;
        bus.host_img_addr = '0; bus.net_addr = '0;
        run_until_ack(30000);
        check("big_busy", busy_cnt - b_busy, 26867);
        check("big_sb_drain", sb.size(), 0);
        check("big_breg", breg_cnt - b_breg, 7);
        check("big_wreg", wreg_cnt - b_wreg, 3500);
        check("big_valid", valid_cnt - b_valid, 8960);
        check("big_serial_we", sw_cnt - b_sw, 448);
        check("big_bias_wrap", last_bias, 11'd1458);
        check("big_no_busy_writes", busy_wr_cnt - b_bw, 0);
        tick();

        // Reset in the middle of ACC, then a fresh layer
        start_layer(8, 1, 6, 3, 0, 12'd40, 12'd3000);
        wait_state(2'd2, 100);
        for (int c = 0; c < 5; c++) tick();
        rst = 1'b1;
        tick();
        check("midrst_state", bus.core_state, 2'd0);
        check("midrst_outs", {bus.ack, bus.buf_pix_en, bus.mem_img_addr, bus.first_input,
                              bus.last_input, bus.out_valid, bus.serial_we, bus.serial_addr,
                              bus.mem_net_addr}, '0);
        rst = 1'b0;
        tick();
        snap();
        acc_chk = 1'b1; acc_base = 12'd40;
        push_out(3, 4, 12'd500);
        start_layer(3, 1, 6, 3, 1, 12'd40, 12'd500);
        check("restart_state", bus.core_state, 2'd1);
        check("restart_addr", {bus.mem_net_addr, bus.first_input}, {11'd0, 1'b1});
        run_until_ack(500);
        check("restart_sb_drain", sb.size(), 0);
        check("restart_valid", valid_cnt - b_valid, 4);
        check("restart_stop", stop_idx, 28);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
